// File: rtl/muldiv.sv
// Iterative RV32M multiply/divide unit running beside the ALU in the execute stage.
// A request is taken in IDLE. The unit then spends XLEN cycles in RUN. It pulses
// done for one cycle when result is valid. Divide-by-zero and signed overflow skip
// RUN and go straight to DONE.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start            request, sampled only in IDLE
//   funct3           op select (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   read1, read2     rs1 / rs2 operands
//   busy             high while iterating
//   done             one-cycle pulse, result valid
//   result           registered result, held until the next completion
module muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] read1,
    input  logic [XLEN-1:0] read2,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam int unsigned AW = 2 * XLEN;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic            r_neg;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [AW-1:0]   r_acc;
    logic            r_busy;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;

    // Operand decode at the start edge: signedness, magnitudes, result sign, special cases
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_neg;
    logic            w_div0;
    logic            w_ovf;
    logic [XLEN-1:0] w_special_val;

    always_comb begin
        w_is_div   = funct3[2];
        w_a_signed = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01 || funct3[1:0] == 2'b10);
        w_b_signed = w_is_div ? ~funct3[0] : (funct3[1:0] == 2'b01);
        w_a_neg    = w_a_signed & read1[XLEN-1];
        w_b_neg    = w_b_signed & read2[XLEN-1];
        w_a_mag    = w_a_neg ? XLEN'(-read1) : read1;
        w_b_mag    = w_b_neg ? XLEN'(-read2) : read2;
        // Remainder follows the dividend; quotient and product follow the sign product
        w_neg      = (w_is_div && funct3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_div0     = w_is_div && (read2 == '0);
        w_ovf      = w_is_div && !funct3[0]
                     && (read1 == {1'b1, {(XLEN-1){1'b0}}}) && (read2 == '1);
        // Overflow quotient equals the dividend itself (most negative value)
        if (w_div0)
            w_special_val = funct3[1] ? read1 : '1;
        else
            w_special_val = funct3[1] ? '0 : read1;
    end

    // One iteration of shift-add multiply or restoring divide on the accumulator
    logic [XLEN:0]   w_mul_sum;
    logic [AW-1:0]   w_mul_next;
    logic [XLEN:0]   w_rem_sh;
    logic [XLEN:0]   w_diff;
    logic [AW-1:0]   w_div_next;
    logic [AW-1:0]   w_acc_next;
    logic [AW-1:0]   w_prod;
    logic [XLEN-1:0] w_dsel;
    logic [XLEN-1:0] w_final;

    always_comb begin
        // Multiply: multiplier sits in the low half and shifts out one bit per cycle
        w_mul_sum  = {1'b0, r_acc[AW-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
        w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};
        // Divide: {remainder, dividend/quotient} shift left; a borrow means restore
        w_rem_sh   = r_acc[AW-1:XLEN-1];
        w_diff     = w_rem_sh - {1'b0, r_b};
        if (w_diff[XLEN])
            w_div_next = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        else
            w_div_next = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_acc_next = r_op[2] ? w_div_next : w_mul_next;

        w_prod  = r_neg ? AW'(-w_acc_next) : w_acc_next;
        w_dsel  = r_op[1] ? w_acc_next[AW-1:XLEN] : w_acc_next[XLEN-1:0];
        if (r_op[2])
            w_final = r_neg ? XLEN'(-w_dsel) : w_dsel;
        else if (r_op[1:0] == 2'b00)
            w_final = w_prod[XLEN-1:0];
        else
            w_final = w_prod[AW-1:XLEN];
    end

    // Control FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op  <= funct3;
                        r_neg <= w_neg;
                        r_a   <= w_a_mag;
                        r_b   <= w_b_mag;
                        r_acc <= w_is_div ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
                        r_cnt <= '0;
                        if (w_div0 || w_ovf) begin
                            r_result <= w_special_val;
                            r_done   <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(XLEN-1)) begin
                        r_result <= w_final;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, parallel to the ALU.
- Fed from the same register-file operands and funct3 field as the ALU.
- Selected by decode when the R-type instruction has funct7 = 0000001.
- The core stalls on busy and writes back result when done pulses.

Parameters:
XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-low
start  input  1  request; sampled only in IDLE
funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
read1  input  XLEN  rs1 operand (multiplicand / dividend)
read2  input  XLEN  rs2 operand (multiplier / divisor)
busy  output  1  high while iterating
done  output  1  one-cycle pulse; result valid
result  output  XLEN  registered result; held until next completion

Behaviour:
- Reset (rst_n low, any time, including mid-operation):
  - State goes to IDLE; busy=0, done=0, result=0.
  - Iteration counter, operand and accumulator registers are cleared; any in-flight operation is discarded.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On an edge with start=1: latch funct3, read1 and read2.
  - Compute operand magnitudes and the result sign; clear the counter.
  - Next state is RUN, or DONE when a special case applies (see below).
  - start=0: stay in IDLE.
- RUN:
  - busy=1; one iteration per edge; counter increments 0..XLEN-1.
  - Multiply: unsigned shift-add over the 2*XLEN accumulator, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - On the edge where counter=XLEN-1: apply sign correction (two's-complement negate when required), select the low or high half, or the quotient or remainder, and load result. Next state is DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; next state is IDLE.
- start is ignored in RUN and DONE. Operand changes after the start edge have no effect.
- Latency:
  - Normal op: done is high in the cycle after the edge that is XLEN edges after the start edge (32 for XLEN=32).
  - Special case: done is high in the cycle after the start edge.
  - Back-to-back: a new start is accepted at the earliest in the cycle after done.
- Arithmetic:
  - MUL: low XLEN bits of the product; identical for any signedness.
  - MULH: high half, signed×signed. MULHSU: high half, signed rs1 × unsigned rs2. MULHU: high half, unsigned×unsigned.
  - DIV/DIVU: quotient truncated toward zero.
  - REM/REMU: remainder takes the sign of the dividend; |rem| < |divisor|.
- Special cases (no iteration, go straight to DONE):
  - Divisor=0: DIV/DIVU give all ones; REM/REMU give read1.
  - Signed overflow (DIV/REM with read1=0x80000000 and read2=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
  - MUL-class ops never take a special path, even with a zero operand.
- result changes only on the DONE-entry edge or on reset.

Test Plan:
- Multiply group (each via start, wait for done):
  - MUL 7×0xFFFFFFFD -> result 0xFFFFFFEB, done exactly 32 cycles after the start edge, busy high for 32 cycles.
  - MULH 0x80000000×0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- Divide group: DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- Special cases, each with done one cycle after start and busy never high:
  - DIVU 5/0 -> 0xFFFFFFFF.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000.
  - REM same operands -> 0.
- Protocol:
  - Hold start high through a MUL 3×4 and change the operands mid-run -> exactly one done, result 12.
  - A second start in the cycle after done is accepted.
- Reset mid-operation: drop rst_n at iteration 10 of a DIVU -> busy, done and result go to 0 immediately (asynchronous). After release, MULHU 2×3 -> 0.
- Randomised: 10k random funct3/operand pairs against a reference model -> all results match, done pulse width is always 1.
